// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default array depth and response error codes.
package dmem_responder_pkg;

   localparam int unsigned DEPTH_DEFAULT = 4096;

   // IDLE = 0, HI = 1, RESP = 2
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StHi   = 2'd1,
      StResp = 2'd2
   } state_e;

   localparam logic RSP_OK        = 1'b0;
   localparam logic RSP_ERR_RANGE = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 16-bit storage array.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high clear of every word
//   we     - write enable (synchronous)
//   addr   - word index, shared by read and write (single port)
//   wdata  - write data
//   rdata  - combinational read data at addr
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter int unsigned IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [IW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem <= '{default: 16'h0000};
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the pipeline's data-memory request interface.
// Narrow (16-bit) accesses complete in one array beat; wide (32-bit) accesses
// take a low beat at accept and a high beat in HI, during which busy stalls
// the requester. Responses are registered and carry a range-error flag.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_write, req_wide   - op type and access size
//   req_addr, req_wdata   - word address (low half for wide) and write data
//   rsp_valid             - one-cycle response pulse
//   rsp_rdata, rsp_err    - registered read data / out-of-range flag
//   busy                  - high during the second beat of a wide access
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter int unsigned AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic          req_wide,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          busy
);

   localparam int unsigned IW = $clog2(DEPTH);

   state_e        state_q, state_d;
   logic [IW-1:0] hi_addr_q;
   logic [15:0]   whi_q;
   logic [15:0]   lo_q;
   logic          wr_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic          accept;
   logic          addr_err;
   logic [IW-1:0] arr_addr;
   logic          arr_we;
   logic [15:0]   arr_wdata;
   logic [15:0]   arr_rdata;

   // Gated by reset so the requester sees no readiness while held in reset.
   assign req_ready = ~reset & (state_q != StHi);
   assign accept    = req_valid & req_ready;

   // A wide access must fit entirely: its high word at addr+1 must be in range.
   assign addr_err = req_wide ? (req_addr >= AW'(DEPTH - 1)) : (req_addr >= AW'(DEPTH));

   always_comb begin
      state_d   = state_q;
      arr_addr  = req_addr[IW-1:0];
      arr_we    = 1'b0;
      arr_wdata = req_wdata[15:0];
      case (state_q)
         StHi: begin
            arr_addr  = hi_addr_q;
            arr_we    = wr_q;
            arr_wdata = whi_q;
            state_d   = StResp;
         end
         default: begin
            if (accept) begin
               if (addr_err) begin
                  state_d = StResp;
               end else begin
                  arr_we  = req_write;
                  state_d = req_wide ? StHi : StResp;
               end
            end else begin
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         hi_addr_q <= '0;
         whi_q     <= '0;
         lo_q      <= '0;
         wr_q      <= 1'b0;
         rdata_q   <= '0;
         err_q     <= RSP_OK;
      end else begin
         state_q <= state_d;
         if (state_q == StHi) begin
            rdata_q <= wr_q ? 32'h0 : {arr_rdata, lo_q};
            err_q   <= RSP_OK;
         end else if (accept) begin
            if (addr_err) begin
               rdata_q <= '0;
               err_q   <= RSP_ERR_RANGE;
            end else if (req_wide) begin
               // Low half is held aside so the visible response only changes
               // when the complete word is loaded.
               hi_addr_q <= arr_addr + IW'(1);
               whi_q     <= req_wdata[31:16];
               wr_q      <= req_write;
               lo_q      <= arr_rdata;
            end else begin
               rdata_q <= req_write ? 32'h0 : {16'h0000, arr_rdata};
               err_q   <= RSP_OK;
            end
         end
      end
   end

   assign rsp_valid = (state_q == StResp);
   assign busy      = (state_q == StHi);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   dmem_array #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_wide;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int tests_run;
   int tests_failed;

   dmem_responder #(
      .DEPTH (4096),
      .AW    (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_wide  (req_wide),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request at a negedge, wait (bounded) for its response.
   // Returns latency in cycles after accept, number of busy cycles seen,
   // and the response data/flag. Leaves the bench one cycle past the response.
   task automatic xact(input logic w, input logic wd, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output int busy_n,
                       output logic [31:0] rd, output logic er);
      req_valid = 1'b1;
      req_write = w;
      req_wide  = wd;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat    = 1;
      busy_n = 0;
      while (!rsp_valid && lat < 6) begin
         busy_n += int'(busy);
         @(negedge clk);
         lat++;
      end
      busy_n += int'(busy);
      rd = rsp_rdata;
      er = rsp_err;
      @(negedge clk);
   endtask

   int          lat;
   int          bn;
   logic [31:0] rd;
   logic        er;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_wide  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);

      // Narrow read of cleared addr 5
      xact(1'b0, 1'b0, 32'd5, 32'h0, lat, bn, rd, er);
      chk("rd5_lat", lat, 1);
      chk("rd5_data", rd, 32'h0);
      chk("rd5_err", {31'b0, er}, 32'd0);
      chk("rd5_busy", bn, 0);

      // Narrow write 10, read 10 issued in the write's RESP cycle
      req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b0;
      req_addr = 32'd10; req_wdata = 32'hFFFF1234;
      chk("raw_ready0", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_write = 1'b0;
      chk("raw_wr_rsp", {31'b0, rsp_valid}, 32'd1);
      chk("raw_wr_rdata", rsp_rdata, 32'h0);
      chk("raw_ready1", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("raw_rd_rsp", {31'b0, rsp_valid}, 32'd1);
      chk("raw_rd_rdata", rsp_rdata, 32'h00001234);
      chk("raw_ready2", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      chk("raw_idle", {31'b0, rsp_valid}, 32'd0);

      // Wide write/read at 2046 (last legal wide address is 4094)
      xact(1'b1, 1'b1, 32'd2046, 32'hABCD5678, lat, bn, rd, er);
      chk("ww_lat", lat, 2);
      chk("ww_busy", bn, 1);
      chk("ww_rdata", rd, 32'h0);
      chk("ww_err", {31'b0, er}, 32'd0);
      xact(1'b0, 1'b0, 32'd2046, 32'h0, lat, bn, rd, er);
      chk("ww_lo", rd, 32'h00005678);
      xact(1'b0, 1'b0, 32'd2047, 32'h0, lat, bn, rd, er);
      chk("ww_hi", rd, 32'h0000ABCD);
      xact(1'b0, 1'b1, 32'd2046, 32'h0, lat, bn, rd, er);
      chk("wr_lat", lat, 2);
      chk("wr_data", rd, 32'hABCD5678);
      chk("wr_busy", bn, 1);

      // Range boundaries
      xact(1'b1, 1'b0, 32'd4095, 32'h00001111, lat, bn, rd, er);
      chk("nw4095_err", {31'b0, er}, 32'd0);
      xact(1'b1, 1'b0, 32'd0, 32'h00002222, lat, bn, rd, er);
      xact(1'b1, 1'b1, 32'd4095, 32'h99998888, lat, bn, rd, er);
      chk("wide4095_err", {31'b0, er}, 32'd1);
      chk("wide4095_lat", lat, 1);
      chk("wide4095_busy", bn, 0);
      chk("wide4095_rdata", rd, 32'h0);
      xact(1'b0, 1'b0, 32'd4095, 32'h0, lat, bn, rd, er);
      chk("m4095_kept", rd, 32'h00001111);
      chk("m4095_err", {31'b0, er}, 32'd0);
      xact(1'b0, 1'b0, 32'd0, 32'h0, lat, bn, rd, er);
      chk("m0_kept", rd, 32'h00002222);
      xact(1'b1, 1'b0, 32'd4096, 32'h00003333, lat, bn, rd, er);
      chk("nw4096_err", {31'b0, er}, 32'd1);
      chk("nw4096_lat", lat, 1);
      chk("err_hold", {31'b0, rsp_err}, 32'd1);
      xact(1'b0, 1'b0, 32'hFFFF_0000, 32'h0, lat, bn, rd, er);
      chk("nr_big_err", {31'b0, er}, 32'd1);
      chk("nr_big_rdata", rd, 32'h0);
      xact(1'b0, 1'b1, 32'd4094, 32'h0, lat, bn, rd, er);
      chk("wr4094_err", {31'b0, er}, 32'd0);
      chk("wr4094_data", rd, 32'h11110000);

      // Request held during HI
      req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1;
      req_addr = 32'd300; req_wdata = 32'hCAFEBABE;
      @(posedge clk);
      @(negedge clk);
      req_write = 1'b0; req_wide = 1'b0; req_addr = 32'd2046;
      chk("hold_hi_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_hi_busy", {31'b0, busy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("hold_wrsp", {31'b0, rsp_valid}, 32'd1);
      chk("hold_resp_ready", {31'b0, req_ready}, 32'd1);
      chk("hold_resp_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("hold_rd_rsp", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rd_data", rsp_rdata, 32'h00005678);
      @(negedge clk);
      xact(1'b0, 1'b0, 32'd301, 32'h0, lat, bn, rd, er);
      chk("hold_hi_word", rd, 32'h0000CAFE);

      // Reset in the middle of a wide write to 100
      req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1;
      req_addr = 32'd100; req_wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_busy_pre", {31'b0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("abort_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_idle_ready", {31'b0, req_ready}, 32'd1);
      chk("abort_idle_rsp", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
      xact(1'b0, 1'b0, 32'd100, 32'h0, lat, bn, rd, er);
      chk("abort_m100", rd, 32'h0);
      chk("abort_m100_lat", lat, 1);
      xact(1'b0, 1'b0, 32'd10, 32'h0, lat, bn, rd, er);
      chk("abort_m10_cleared", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data-memory request interface driven by the pipeline memory stage.
- Accepts 16-bit (narrow) and 32-bit (wide, two-beat) read/write requests. Wide requests are used for PC push/pop.
- Sequences a wide access into two 16-bit array beats and asserts busy during the second beat, so the requester stalls.
- Returns a registered response with an error flag for out-of-range addresses.

Parameters:
- DEPTH, 4096, number of 16-bit words in the array.
- AW, 32, request address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_wide  in  1  1 = 32-bit two-beat access, 0 = 16-bit access.
- req_addr  in  AW  word address; for wide accesses, the low-half address.
- req_wdata  in  32  write data; narrow writes use bits [15:0] only.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data. Narrow reads are zero-extended. Writes and errors return 0.
- rsp_err  out  1  address out of range; valid only with rsp_valid.
- busy  out  1  high while the second beat of a wide access is in progress.

Behaviour:
- Reset:
  - Asynchronous; all array words are cleared to 0 and state goes to IDLE.
  - req_ready, rsp_valid, rsp_err and busy are 0; rsp_rdata = 0.
  - A reset in the middle of a wide access aborts it with no response.
- States: IDLE, HI, RESP.
- Accept:
  - req_ready = 1 in IDLE and RESP, 0 in HI.
  - A request is accepted on the rising edge where req_valid & req_ready.
- Range check at accept:
  - Narrow request: error when req_addr >= DEPTH.
  - Wide request: error when req_addr >= DEPTH-1; no partial write and no wrap to address 0.
  - On error: no array access, go to RESP with rsp_err = 1 and rsp_rdata = 0. A wide request never enters HI on error.
- Narrow request, accept edge:
  - Write: mem[addr] <= wdata[15:0].
  - Read: rdata <= {16'h0, mem[addr]}.
  - Next state RESP, so the response comes 1 cycle after accept.
- Wide request, accept edge:
  - Low beat. Write: mem[addr] <= wdata[15:0]. Read: rdata[15:0] <= mem[addr].
  - Latch addr+1, the high half of wdata, and the op type.
  - Next state HI.
- HI state:
  - busy = 1, req_ready = 0.
  - At the edge: write mem[addr+1] <= wdata[31:16], or read rdata[31:16] <= mem[addr+1].
  - Next state RESP, so the response comes 2 cycles after accept.
- RESP state:
  - rsp_valid = 1 for exactly one cycle.
  - If a new request is accepted in RESP, it is processed as from IDLE; otherwise go to IDLE.
  - Back-to-back narrow throughput is 1 request per cycle.
- Output hold: rsp_rdata and rsp_err are registered. They hold their value until the next response is loaded and are 0 for write responses.
- Read-after-write: a read accepted in the RESP cycle of a write to the same address returns the new data, because the write committed at its earlier edge.
- Single-port array: at most one array access per clock edge.

Decomposition:
- Shared package:
  - State encoding constants: IDLE = 2'd0, HI = 2'd1, RESP = 2'd2.
  - DEPTH default.
  - Response error code constant.
- One sub-module, dmem_array:
  - DEPTH x 16 storage with synchronous write and combinational read.
  - Asynchronous active-high clear.
  - Instantiated once.
- The FSM, range check and data latching live in dmem_responder.

Test Plan:
- Reset, then narrow read of addr 5 -> rsp_valid 1 cycle after accept, rsp_rdata = 0x00000000, rsp_err = 0, busy never 1.
- Narrow write 0x1234 to addr 10, then narrow read of addr 10 issued in the write's RESP cycle -> rsp_rdata = 0x00001234; req_ready stays 1 throughout.
- Wide write 0xABCD5678 to addr 2046 -> busy = 1 for exactly 1 cycle; mem[2046] = 0x5678, mem[2047] = 0xABCD. Then a wide read of 2046 -> rsp_valid 2 cycles after accept, rsp_rdata = 0xABCD5678.
- Wide write to addr 4095 (DEPTH 4096) -> rsp_err = 1 one cycle after accept, busy never 1, mem[4095] and mem[0] unchanged. Narrow write to addr 4096 -> rsp_err = 1.
- req_valid held during HI -> req_ready = 0 in HI; the request is accepted at the RESP-cycle edge and its response follows the normal latency.
- Assert reset during HI of a wide write to addr 100 -> busy, rsp_valid and req_ready drop immediately. After release, a narrow read of addr 100 returns 0 and the FSM is in IDLE.
